// File: rtl/viterbi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : viterbi_pkg
// Purpose  : Definitions shared by the Viterbi back-end blocks: the width of a
//            survivor path word, the bit-index width, the serializer FSM state
//            encoding and the default buffer depth.
// Revision : 1.0 - initial release
// ============================================================================
package viterbi_pkg;

  localparam int PATH_W             = 8;
  localparam int IDX_W              = 3;
  localparam int DEFAULT_FIFO_DEPTH = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

endpackage
`default_nettype wire

// File: rtl/path_word_fifo.sv
`default_nettype none
// ============================================================================
// Module   : path_word_fifo
// Purpose  : Small synchronous FIFO that buffers survivor path words between
//            the selector stage and the bit serializer.
// Ports    : clk, rst (async, active-high)
//            push/din   - write request and data
//            pop/dout   - read request; dout shows the head word (show-ahead)
//            full/empty - status flags
//            level      - number of occupied entries (0..DEPTH)
// Revision : 1.0 - initial release
// ============================================================================
module path_word_fifo
  import viterbi_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [PATH_W-1:0] din,
  input  logic              pop,
  output logic [PATH_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       level
);

  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [PATH_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q,  level_d;
  logic              wr_en;
  logic              rd_en;

  assign full  = (level_q == FULL_LVL);
  assign empty = (level_q == '0);
  assign level = level_q;
  assign dout  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only taken when the head leaves on the same
  // edge; the write slot then coincides with the slot being read out.
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + (AW + 1)'(1);
      2'b01:   level_d = level_q - (AW + 1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/decoded_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : decoded_bit_serializer
// Purpose  : Captures survivor path words announced by a toggling renew_in
//            strobe, buffers them and streams each word out MSB first over a
//            valid/ready bit interface.
// Ports    : clk, rst (async, active-high)
//            path_in[7:0], renew_in      - word input, one toggle per word
//            bit_out, bit_valid, bit_last - serial output (last = bit 0)
//            bit_ready                    - downstream accept
//            fifo_level                   - buffered words
//            overflow, drop_count[7:0]    - only with DEC_SER_OVERFLOW_EN
// Config   : define DEC_SER_OVERFLOW_EN to add sticky overflow flag and a
//            saturating dropped-word counter.
// Revision : 1.0 - initial release
// ============================================================================
module decoded_bit_serializer
  import viterbi_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PATH_W-1:0] path_in,
  input  logic              renew_in,
  output logic              bit_out,
  output logic              bit_valid,
  input  logic              bit_ready,
  output logic              bit_last,
  output logic [LVL_W-1:0]  fifo_level
`ifdef DEC_SER_OVERFLOW_EN
  ,
  output logic              overflow,
  output logic [7:0]        drop_count
`endif
);

  ser_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [PATH_W-1:0] shift_reg_q, shift_reg_d;
  logic              renew_q;

  logic              word_event;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [PATH_W-1:0] fifo_dout;

  // renew_in is already synchronous to clk; a toggle marks a new word.
  assign word_event = renew_in ^ renew_q;

  path_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (word_event),
    .din   (path_in),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shift_reg_d = shift_reg_q;
    fifo_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          shift_reg_d = fifo_dout;
          idx_d       = 3'd7;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        // bit_valid is high throughout SHIFT, so bit_ready alone is the handshake.
        if (bit_ready) begin
          if (idx_q != 3'd0) begin
            idx_d = idx_q - 3'd1;
          end else if (!fifo_empty) begin
            // Reload on the last handshake so the stream has no bubble.
            fifo_pop    = 1'b1;
            shift_reg_d = fifo_dout;
            idx_d       = 3'd7;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      shift_reg_q <= '0;
      renew_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shift_reg_q <= shift_reg_d;
      renew_q     <= renew_in;
    end
  end

  // Outputs decode straight from registers, so they hold steady under
  // backpressure and clear as soon as rst asserts.
  assign bit_valid = (state_q == SHIFT);
  assign bit_out   = bit_valid & shift_reg_q[idx_q];
  assign bit_last  = bit_valid & (idx_q == 3'd0);

`ifdef DEC_SER_OVERFLOW_EN
  logic       word_drop;
  logic       overflow_q, overflow_d;
  logic [7:0] drop_count_q, drop_count_d;

  // Same condition under which the FIFO refuses the push.
  assign word_drop = word_event & fifo_full & ~fifo_pop;

  always_comb begin
    overflow_d   = overflow_q | word_drop;
    drop_count_d = drop_count_q;
    if (word_drop && (drop_count_q != 8'hFF)) drop_count_d = drop_count_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decoded_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoded_bit_serializer
// Purpose  : Self-checking bench for decoded_bit_serializer. Expected bits are
//            queued when a word is sent and compared on every output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decoded_bit_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] path_in = 8'h00;
  logic       renew_in = 1'b0;
  logic       bit_ready = 1'b0;
  logic       bit_out;
  logic       bit_valid;
  logic       bit_last;
  logic [2:0] fifo_level;
`ifdef DEC_SER_OVERFLOW_EN
  logic       overflow;
  logic [7:0] drop_count;
`endif

  int checks   = 0;
  int failures = 0;
  logic [1:0] sb[$];  // {bit, last}

  always #5 clk = ~clk;

  decoded_bit_serializer #(
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .path_in    (path_in),
    .renew_in   (renew_in),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .bit_last   (bit_last),
    .fifo_level (fifo_level)
`ifdef DEC_SER_OVERFLOW_EN
    ,
    .overflow   (overflow),
    .drop_count (drop_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    renew_in = 1'b0;
    path_in = 8'h00;
    bit_ready = 1'b0;
    #2;
    sb.delete();
    tick();
    rst = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input bit kept);
    path_in = w;
    renew_in = ~renew_in;
    if (kept) begin
      for (int i = 7; i >= 0; i--) sb.push_back({w[i], (i == 0)});
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    bit_ready = 1'b1;
    while ((sb.size() != 0 || bit_valid) && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0 || bit_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_drain: got pending=%0d valid=%b, expected pending=0 valid=0",
               name, sb.size(), bit_valid);
    end
  endtask

  task automatic monitor();
    logic [1:0] exp;
    forever begin
      @(negedge clk);
      if (!rst && bit_valid === 1'b1 && bit_ready === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_bit: got bit=%b last=%b, expected no output", bit_out, bit_last);
        end else begin
          exp = sb.pop_front();
          if ({bit_out, bit_last} !== exp) begin
            failures++;
            $display("FAIL bit_stream: got bit=%b last=%b, expected bit=%b last=%b",
                     bit_out, bit_last, exp[1], exp[0]);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #3;
    checks++;
    if ({bit_valid, bit_out, bit_last} !== 3'b000) begin
      failures++;
      $display("FAIL reset_outputs: got %b, expected 000", {bit_valid, bit_out, bit_last});
    end
    checks++;
    if (fifo_level !== 3'd0) begin
      failures++;
      $display("FAIL reset_level: got %0d, expected 0", fifo_level);
    end
`ifdef DEC_SER_OVERFLOW_EN
    checks++;
    if (overflow !== 1'b0 || drop_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_overflow: got ovf=%b cnt=%0d, expected 0/0", overflow, drop_count);
    end
`endif
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_single_word();
    apply_reset();
    bit_ready = 1'b1;
    send_word(8'hA5, 1'b1);
    tick();
    checks++;
    if (bit_valid !== 1'b0) begin
      failures++;
      $display("FAIL latency_t1: got valid=%b, expected 0", bit_valid);
    end
    tick();
    checks++;
    if (bit_valid !== 1'b1 || bit_out !== 1'b1) begin
      failures++;
      $display("FAIL latency_t2: got valid=%b bit=%b, expected 1/1", bit_valid, bit_out);
    end
    drain("single");
  endtask

  task automatic test_back_to_back();
    apply_reset();
    bit_ready = 1'b1;
    send_word(8'hFF, 1'b1);
    tick();
    tick();
    send_word(8'h00, 1'b1);
    for (int i = 0; i < 16; i++) begin
      if (i != 0) tick();
      checks++;
      if (bit_valid !== 1'b1) begin
        failures++;
        $display("FAIL b2b_no_bubble[%0d]: got valid=%b, expected 1", i, bit_valid);
      end
    end
    tick();
    checks++;
    if (bit_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end: got valid=%b, expected 0", bit_valid);
    end
    drain("b2b");
  endtask

  task automatic test_backpressure();
    apply_reset();
    bit_ready = 1'b1;
    send_word(8'h3C, 1'b1);
    repeat (5) tick();  // now on bit index 4
    bit_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i != 0) tick();
      checks++;
      if ({bit_valid, bit_out, bit_last} !== 3'b110) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got valid/bit/last=%b, expected 110",
                 i, {bit_valid, bit_out, bit_last});
      end
    end
    drain("bp");
  endtask

  task automatic test_overflow();
    logic [7:0] words [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      send_word(words[i], (i < 5));
      tick();
    end
    checks++;
    if (fifo_level !== 3'd4) begin
      failures++;
      $display("FAIL ovf_level: got %0d, expected 4", fifo_level);
    end
    checks++;
    if (bit_valid !== 1'b1 || bit_out !== 1'b0) begin
      failures++;
      $display("FAIL ovf_shift_word: got valid=%b bit=%b, expected 1/0", bit_valid, bit_out);
    end
`ifdef DEC_SER_OVERFLOW_EN
    checks++;
    if (overflow !== 1'b1 || drop_count !== 8'd1) begin
      failures++;
      $display("FAIL ovf_flag: got ovf=%b cnt=%0d, expected 1/1", overflow, drop_count);
    end
`endif
    drain("ovf");
`ifdef DEC_SER_OVERFLOW_EN
    checks++;
    if (overflow !== 1'b1 || drop_count !== 8'd1) begin
      failures++;
      $display("FAIL ovf_sticky: got ovf=%b cnt=%0d, expected 1/1", overflow, drop_count);
    end
`endif
  endtask

  task automatic test_full_push_pop();
    logic [7:0] words [5] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      send_word(words[i], 1'b1);
      tick();
    end
    checks++;
    if (fifo_level !== 3'd4) begin
      failures++;
      $display("FAIL full_level_before: got %0d, expected 4", fifo_level);
    end
    bit_ready = 1'b1;
    repeat (7) tick();  // now on the word-completing handshake
    send_word(8'h5E, 1'b1);
    tick();
    checks++;
    if (fifo_level !== 3'd4) begin
      failures++;
      $display("FAIL full_pushpop_level: got %0d, expected 4", fifo_level);
    end
`ifdef DEC_SER_OVERFLOW_EN
    checks++;
    if (overflow !== 1'b0 || drop_count !== 8'd0) begin
      failures++;
      $display("FAIL full_pushpop_nodrop: got ovf=%b cnt=%0d, expected 0/0", overflow, drop_count);
    end
`endif
    drain("full");
  endtask

  task automatic test_reset_mid_stream();
    apply_reset();
    bit_ready = 1'b1;
    send_word(8'hC3, 1'b1);
    tick();
    send_word(8'hE7, 1'b1);
    repeat (5) tick();  // now on bit index 3 of 8'hC3
    checks++;
    if (bit_valid !== 1'b1 || bit_out !== 1'b0 || fifo_level !== 3'd1) begin
      failures++;
      $display("FAIL mid_pre_reset: got valid=%b bit=%b level=%0d, expected 1/0/1",
               bit_valid, bit_out, fifo_level);
    end
    #2;
    rst = 1'b1;
    renew_in = 1'b0;
    sb.delete();
    #1;
    checks++;
    if ({bit_valid, bit_out, bit_last} !== 3'b000 || fifo_level !== 3'd0) begin
      failures++;
      $display("FAIL mid_reset_async: got vbl=%b level=%0d, expected 000/0",
               {bit_valid, bit_out, bit_last}, fifo_level);
    end
    tick();
    rst = 1'b0;
    send_word(8'h5A, 1'b1);
    drain("mid_reset");
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_full_push_pop();
    test_reset_mid_stream();
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
